painterengine_gpu_dma_reader: RTL and testbench

PAINTERENGINE_GPU_DMA_READER -- requirements
Module: painterengine_gpu_dma_reader

---
 rtl/painterengine_gpu_dma_reader_if.sv | 40 ++++
 rtl/painterengine_gpu_dma_reader.sv | 211 +++++++++++++++++++++
 tb/tb_painterengine_gpu_dma_reader.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/painterengine_gpu_dma_reader_if.sv
`default_nettype none
// ============================================================================
// painterengine_gpu_dma_reader_if
// AXI4 read-channel bundle (AR + R) used by the GPU DMA reader.
// Revision: 1.0
// ============================================================================
interface painterengine_gpu_dma_reader_if;
    logic [0:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic        arvalid;
    logic        arready;
    logic [0:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/painterengine_gpu_dma_reader.sv
`default_nettype none
// ============================================================================
// painterengine_gpu_dma_reader
// Streams a word-aligned memory region over AXI4 bursts into a show-ahead FIFO.
// Revision: 1.0
// ============================================================================
module painterengine_gpu_dma_reader #(
    parameter int PARAM_FIFO_DEPTH = 32,
    parameter int PARAM_MAX_BURST  = 16
) (
    input  wire logic        i_wire_clock,
    input  wire logic        i_wire_resetn,
    input  wire logic        i_wire_start,
    input  wire logic [31:0] i_wire_address,
    input  wire logic [31:0] i_wire_length,
    output logic             o_wire_done,
    output logic             o_wire_error,
    output logic [31:0]      o_wire_data,
    output logic             o_wire_data_valid,
    input  wire logic        i_wire_data_next,
    painterengine_gpu_dma_reader_if.master m_axi
);
    localparam int PTR_W = (PARAM_FIFO_DEPTH > 1) ? $clog2(PARAM_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0] AR_TIMEOUT_LAST = 8'hFF;

    typedef enum logic [4:0] {
        S_IDLE           = 5'h00,
        S_CHECK          = 5'h02,
        S_CALC           = 5'h03,
        S_ADDR           = 5'h04,
        S_DATA           = 5'h05,
        S_DRAIN          = 5'h06,
        S_DONE           = 5'h07,
        S_WAIT_SPACE     = 5'h08,
        S_ERR_ALIGN      = 5'h10,
        S_ERR_LENGTH     = 5'h11,
        S_ERR_AR_TIMEOUT = 5'h12,
        S_ERR_RRESP      = 5'h13,
        S_ERR_RLAST      = 5'h14
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        len_q, len_d;
    logic [31:0]        offset_q, offset_d;
    logic [31:0]        burst_addr_q, burst_addr_d;
    logic [7:0]         arlen_q, arlen_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic [7:0]         ar_timer_q, ar_timer_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
    logic [31:0]        fifo_mem [PARAM_FIFO_DEPTH];

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_flush;
    logic [31:0] calc_addr;
    logic [31:0] calc_beats;
    logic [31:0] to_4k;
    logic [31:0] remain;
    logic [31:0] burst_beats;
    logic [31:0] fifo_space;
    logic        last_beat;
    logic        unused_ok;

    // The beat count is kept as ARLEN so the bus reset value (ARLEN=0) falls out naturally.
    assign burst_beats = 32'(arlen_q) + 32'd1;
    assign fifo_space  = 32'(PARAM_FIFO_DEPTH) - 32'(fifo_count_q);
    assign last_beat   = (beat_cnt_q == arlen_q);
    assign fifo_pop    = i_wire_data_next && (fifo_count_q != '0);
    assign unused_ok   = ^{m_axi.rid, m_axi.rresp[0]};

    always_comb begin
        calc_addr  = addr_q + {offset_q[29:0], 2'b00};
        to_4k      = 32'd1024 - {22'd0, calc_addr[11:2]};
        remain     = len_q - offset_q;
        calc_beats = to_4k;
        if (remain < calc_beats) calc_beats = remain;
        if (32'(PARAM_MAX_BURST) < calc_beats) calc_beats = 32'(PARAM_MAX_BURST);
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        offset_d     = offset_q;
        burst_addr_d = burst_addr_q;
        arlen_d      = arlen_q;
        beat_cnt_d   = beat_cnt_q;
        ar_timer_d   = ar_timer_q;
        fifo_push    = 1'b0;
        fifo_flush   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (i_wire_start) begin
                    addr_d     = i_wire_address;
                    len_d      = i_wire_length;
                    offset_d   = 32'd0;
                    fifo_flush = 1'b1;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (addr_q[1:0] != 2'b00)  state_d = S_ERR_ALIGN;
                else if (len_q == 32'd0)   state_d = S_ERR_LENGTH;
                else                       state_d = S_CALC;
            end
            S_CALC: begin
                burst_addr_d = calc_addr;
                arlen_d      = 8'(calc_beats - 32'd1);
                beat_cnt_d   = 8'd0;
                state_d      = S_WAIT_SPACE;
            end
            S_WAIT_SPACE: begin
                ar_timer_d = 8'd0;
                if (fifo_space >= burst_beats) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (m_axi.arready)                      state_d = S_DATA;
                else if (ar_timer_q == AR_TIMEOUT_LAST) state_d = S_ERR_AR_TIMEOUT;
                else                                    ar_timer_d = ar_timer_q + 8'd1;
            end
            S_DATA: begin
                if (m_axi.rvalid) begin
                    fifo_push = 1'b1;
                    // A slave error outranks a framing error on the same beat.
                    if (m_axi.rresp[1])                  state_d = S_ERR_RRESP;
                    else if (m_axi.rlast != last_beat)   state_d = S_ERR_RLAST;
                    else if (last_beat) begin
                        beat_cnt_d = 8'd0;
                        offset_d   = offset_q + burst_beats;
                        state_d    = (offset_d == len_q) ? S_DRAIN : S_CALC;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_count_q == '0) state_d = S_DONE;
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (fifo_flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fifo_count_d = '0;
        end else begin
            if (fifo_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (fifo_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            fifo_count_d = fifo_count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        end
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'd0;
            len_q        <= 32'd0;
            offset_q     <= 32'd0;
            burst_addr_q <= 32'd0;
            arlen_q      <= 8'd0;
            beat_cnt_q   <= 8'd0;
            ar_timer_q   <= 8'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            offset_q     <= offset_d;
            burst_addr_q <= burst_addr_d;
            arlen_q      <= arlen_d;
            beat_cnt_q   <= beat_cnt_d;
            ar_timer_q   <= ar_timer_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    always_ff @(posedge i_wire_clock) begin
        if (fifo_push) fifo_mem[wr_ptr_q] <= m_axi.rdata;
    end

    assign o_wire_data       = fifo_mem[rd_ptr_q];
    assign o_wire_data_valid = (fifo_count_q != '0);
    assign o_wire_done       = (state_q == S_DONE);
    assign o_wire_error      = state_q[4];

    assign m_axi.arid    = 1'b0;
    assign m_axi.araddr  = burst_addr_q;
    assign m_axi.arlen   = arlen_q;
    assign m_axi.arsize  = 3'b010;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0010;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arqos   = 4'b0000;
    assign m_axi.arvalid = (state_q == S_ADDR);
    assign m_axi.rready  = (state_q == S_DATA);
endmodule
`default_nettype wire

// File: tb/tb_painterengine_gpu_dma_reader.sv
`default_nettype none
// ============================================================================
// tb_painterengine_gpu_dma_reader
// Directed bench with an AXI read-slave model and a popping consumer.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_painterengine_gpu_dma_reader;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] len = 32'd0;
    logic        next = 1'b0;
    logic        done, error, dvalid;
    logic [31:0] data;

    painterengine_gpu_dma_reader_if axi ();

    painterengine_gpu_dma_reader #(.PARAM_FIFO_DEPTH(32), .PARAM_MAX_BURST(16)) dut (
        .i_wire_clock      (clk),
        .i_wire_resetn     (rstn),
        .i_wire_start      (start),
        .i_wire_address    (addr),
        .i_wire_length     (len),
        .o_wire_done       (done),
        .o_wire_error      (error),
        .o_wire_data       (data),
        .o_wire_data_valid (dvalid),
        .i_wire_data_next  (next),
        .m_axi             (axi.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    bit          arready_en = 1'b1;
    int          rresp_err_beat = -1;
    int          early_last_beat = -1;
    bit          sl_busy = 1'b0;
    logic [31:0] sl_addr = 32'd0;
    int          sl_len = 0;
    int          sl_beat = 0;
    bit          s_ar_hs, s_r_hs;
    logic [31:0] s_ar_addr;
    logic [7:0]  s_ar_len;
    logic [31:0] ar_addr_log[$];
    int          ar_len_log[$];
    int          ar_valid_cycles = 0;
    int          overlap_cnt = 0;
    logic [31:0] got[$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_00C3;
    endfunction

    task automatic drive_slave();
        axi.arready = arready_en;
        axi.rid     = 1'b0;
        axi.rvalid  = sl_busy;
        axi.rdata   = sl_busy ? word_at(sl_addr + 32'(4 * sl_beat)) : 32'd0;
        axi.rresp   = (sl_busy && sl_beat == rresp_err_beat) ? 2'b10 : 2'b00;
        axi.rlast   = sl_busy && (sl_beat == sl_len || sl_beat == early_last_beat);
    endtask

    initial drive_slave();

    // Slave model and consumer monitor: sample at the edge, update 1 ns later.
    always @(posedge clk) begin
        s_ar_hs   = axi.arvalid && axi.arready;
        s_r_hs    = axi.rvalid && axi.rready;
        s_ar_addr = axi.araddr;
        s_ar_len  = axi.arlen;
        if (axi.arvalid) ar_valid_cycles++;
        if (axi.arvalid && sl_busy) overlap_cnt++;
        if (dvalid && next) got.push_back(data);
        #1;
        if (rstn) begin
            if (s_r_hs) begin
                if (sl_beat == sl_len) sl_busy = 1'b0;
                else sl_beat++;
            end
            if (s_ar_hs) begin
                sl_busy = 1'b1;
                sl_addr = s_ar_addr;
                sl_len  = int'(s_ar_len);
                sl_beat = 0;
                ar_addr_log.push_back(s_ar_addr);
                ar_len_log.push_back(int'(s_ar_len));
            end
        end
        drive_slave();
    end

    task automatic clear_logs();
        got.delete();
        ar_addr_log.delete();
        ar_len_log.delete();
        ar_valid_cycles = 0;
        overlap_cnt = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        start = 1'b0;
        next = 1'b0;
        arready_en = 1'b1;
        rresp_err_beat = -1;
        early_last_beat = -1;
        sl_busy = 1'b0;
        sl_beat = 0;
        drive_slave();
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        clear_logs();
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [31:0] l);
        @(posedge clk);
        #2;
        addr = a;
        len = l;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || error) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int bad_words(input logic [31:0] base, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (i >= got.size() || got[i] !== word_at(base + 32'(4 * i))) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({done, error, dvalid} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {done, error, dvalid});
        else n_pass++;
        n_checks++;
        if ({axi.arvalid, axi.rready} !== 2'b00) $display("FAIL reset_handshake: got %b expected 00", {axi.arvalid, axi.rready});
        else n_pass++;
        n_checks++;
        if ({axi.araddr, axi.arlen} !== 40'd0) $display("FAIL reset_ar: got %h expected 0", {axi.araddr, axi.arlen});
        else n_pass++;
        n_checks++;
        if ({axi.arsize, axi.arburst, axi.arcache} !== 9'b010_01_0010) $display("FAIL ar_const: got %b expected 010010010", {axi.arsize, axi.arburst, axi.arcache});
        else n_pass++;
    endtask

    task automatic test_basic();
        bit ok;
        logic [31:0] exp_a[3] = '{32'h1000, 32'h1040, 32'h1080};
        int          exp_l[3] = '{15, 15, 7};
        do_reset();
        next = 1'b1;
        pulse_start(32'h1000, 32'd40);
        wait_end(500, ok);
        n_checks++;
        if (!(ok && done && !error)) $display("FAIL basic_done: got done=%b error=%b expected done=1 error=0", done, error);
        else n_pass++;
        n_checks++;
        if (ar_addr_log.size() !== 3) $display("FAIL basic_ar_count: got %0d expected 3", ar_addr_log.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < ar_addr_log.size(); i++) begin
            n_checks++;
            if (ar_addr_log[i] !== exp_a[i] || ar_len_log[i] !== exp_l[i])
                $display("FAIL basic_ar%0d: got %h/%0d expected %h/%0d", i, ar_addr_log[i], ar_len_log[i], exp_a[i], exp_l[i]);
            else n_pass++;
        end
        n_checks++;
        if (got.size() !== 40 || bad_words(32'h1000, 40) !== 0)
            $display("FAIL basic_words: got %0d words %0d bad expected 40 words 0 bad", got.size(), bad_words(32'h1000, 40));
        else n_pass++;
        n_checks++;
        if (overlap_cnt !== 0) $display("FAIL basic_outstanding: got %0d overlaps expected 0", overlap_cnt);
        else n_pass++;
    endtask

    task automatic test_4k_split();
        bit ok;
        do_reset();
        next = 1'b1;
        pulse_start(32'h0FF8, 32'd4);
        wait_end(200, ok);
        n_checks++;
        if (ar_addr_log.size() !== 2) $display("FAIL split_ar_count: got %0d expected 2", ar_addr_log.size());
        else n_pass++;
        if (ar_addr_log.size() == 2) begin
            n_checks++;
            if (ar_addr_log[0] !== 32'h0FF8 || ar_len_log[0] !== 1 || ar_addr_log[1] !== 32'h1000 || ar_len_log[1] !== 1)
                $display("FAIL split_ar: got %h/%0d %h/%0d expected 00000ff8/1 00001000/1", ar_addr_log[0], ar_len_log[0], ar_addr_log[1], ar_len_log[1]);
            else n_pass++;
        end
        n_checks++;
        if (!ok || !done || got.size() !== 4 || bad_words(32'h0FF8, 4) !== 0)
            $display("FAIL split_words: got done=%b %0d words expected done=1 4 words", done, got.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        pulse_start(32'h2000, 32'd64);
        repeat (200) @(negedge clk);
        n_checks++;
        if (dut.state_q !== 5'h08 || ar_addr_log.size() !== 2 || ar_valid_cycles !== 2 || !dvalid)
            $display("FAIL bp_hold: got state=%h ars=%0d arvalid_cycles=%0d valid=%b expected 08/2/2/1", dut.state_q, ar_addr_log.size(), ar_valid_cycles, dvalid);
        else n_pass++;
        next = 1'b1;
        wait_end(1000, ok);
        n_checks++;
        if (!ok || !done || got.size() !== 64 || bad_words(32'h2000, 64) !== 0)
            $display("FAIL bp_resume: got done=%b %0d words %0d bad expected done=1 64 words 0 bad", done, got.size(), bad_words(32'h2000, 64));
        else n_pass++;
    endtask

    task automatic test_err_align_length();
        do_reset();
        pulse_start(32'h1002, 32'd4);
        repeat (10) @(negedge clk);
        n_checks++;
        if (!error || dut.state_q !== 5'h10 || ar_valid_cycles !== 0)
            $display("FAIL err_align: got error=%b state=%h arvalid_cycles=%0d expected 1/10/0", error, dut.state_q, ar_valid_cycles);
        else n_pass++;
        pulse_start(32'h1000, 32'd4);
        repeat (10) @(negedge clk);
        n_checks++;
        if (dut.state_q !== 5'h10 || ar_valid_cycles !== 0) $display("FAIL err_sticky: got state=%h expected 10", dut.state_q);
        else n_pass++;
        do_reset();
        pulse_start(32'h1003, 32'd0);
        repeat (10) @(negedge clk);
        n_checks++;
        if (dut.state_q !== 5'h10) $display("FAIL err_align_priority: got %h expected 10", dut.state_q);
        else n_pass++;
        do_reset();
        pulse_start(32'h1000, 32'd0);
        repeat (10) @(negedge clk);
        n_checks++;
        if (!error || dut.state_q !== 5'h11) $display("FAIL err_length: got error=%b state=%h expected 1/11", error, dut.state_q);
        else n_pass++;
    endtask

    task automatic test_err_beats();
        bit ok;
        do_reset();
        next = 1'b1;
        rresp_err_beat = 2;
        pulse_start(32'h1000, 32'd16);
        wait_end(200, ok);
        n_checks++;
        if (!ok || !error || dut.state_q !== 5'h13) $display("FAIL err_rresp: got error=%b state=%h expected 1/13", error, dut.state_q);
        else n_pass++;
        do_reset();
        next = 1'b1;
        early_last_beat = 4;
        pulse_start(32'h1000, 32'd16);
        wait_end(200, ok);
        n_checks++;
        if (!ok || !error || dut.state_q !== 5'h14) $display("FAIL err_rlast: got error=%b state=%h expected 1/14", error, dut.state_q);
        else n_pass++;
        do_reset();
        next = 1'b1;
        early_last_beat = 4;
        rresp_err_beat = 4;
        pulse_start(32'h1000, 32'd16);
        wait_end(200, ok);
        n_checks++;
        if (dut.state_q !== 5'h13) $display("FAIL err_rresp_priority: got %h expected 13", dut.state_q);
        else n_pass++;
    endtask

    task automatic test_ar_timeout();
        bit ok;
        do_reset();
        arready_en = 1'b0;
        drive_slave();
        pulse_start(32'h1000, 32'd8);
        wait_end(600, ok);
        n_checks++;
        if (!ok || !error || dut.state_q !== 5'h12 || ar_valid_cycles !== 256)
            $display("FAIL ar_timeout: got state=%h arvalid_cycles=%0d expected 12/256", dut.state_q, ar_valid_cycles);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        bit hit;
        do_reset();
        next = 1'b1;
        pulse_start(32'h1000, 32'd40);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = axi.rready && (got.size() >= 3);
        end
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        n_checks++;
        if (!hit || {axi.arvalid, axi.rready, dvalid, done, error} !== 5'b0 || {axi.araddr, axi.arlen} !== 40'd0)
            $display("FAIL mid_reset: got hit=%b flags=%b ar=%h expected 1/00000/0", hit, {axi.arvalid, axi.rready, dvalid, done, error}, {axi.araddr, axi.arlen});
        else n_pass++;
        sl_busy = 1'b0;
        sl_beat = 0;
        drive_slave();
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        clear_logs();
        pulse_start(32'h3000, 32'd8);
        wait_end(200, ok);
        n_checks++;
        if (!ok || !done || got.size() !== 8 || bad_words(32'h3000, 8) !== 0)
            $display("FAIL mid_restart: got done=%b %0d words expected done=1 8 words", done, got.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_logs();
        pulse_start(32'h4000, 32'd3);
        wait_end(200, ok);
        n_checks++;
        if (!ok || !done || got.size() !== 3 || bad_words(32'h4000, 3) !== 0 || ar_len_log.size() !== 1)
            $display("FAIL b2b: got done=%b %0d words %0d bursts expected done=1 3 words 1 burst", done, got.size(), ar_len_log.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_4k_split();
        test_backpressure();
        test_err_align_length();
        test_err_beats();
        test_ar_timeout();
        test_reset_mid_burst();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of run expected finish before 1 ms");
        $fatal(1);
    end
endmodule
`default_nettype wire
